// File: rtl/bitfield_extract_sched.sv
// Field-table driven bit-slice sequencer: holds one input word and emits its enabled fields one per cycle.
// Optional range checking of table writes (adds cfg_err) is enabled by BITFIELD_EXTRACT_SCHED_RANGE_CHK_EN.
module bitfield_extract_sched #(
  parameter int DATA_W  = 16,
  parameter int NFIELDS = 4,
  parameter int FIELD_W = 8,
  localparam int IDX_W  = $clog2(NFIELDS),
  localparam int LSB_W  = $clog2(DATA_W),
  localparam int LEN_W  = $clog2(FIELD_W) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [LSB_W-1:0]   cfg_lsb,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               cfg_busy,
`ifdef BITFIELD_EXTRACT_SCHED_RANGE_CHK_EN
  output logic               cfg_err,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic [15:0]        field_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // out_data/out_idx/out_last stay stable while out_valid && !out_ready.
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   cur, cur_n;
  logic [DATA_W-1:0]  hold;
  logic [LSB_W-1:0]   lsb_tab [NFIELDS];
  logic [LEN_W-1:0]   len_tab [NFIELDS];

  logic               any_en, has_next;
  logic [IDX_W-1:0]   first_idx, next_idx;
  logic               accept, handoff, cfg_ok;
  logic [LEN_W-1:0]   len_eff;
  logic [FIELD_W-1:0] mask;
  logic [DATA_W+FIELD_W-1:0] wide;

  // Priority scans: lowest enabled entry overall, and lowest enabled entry above cur.
  always_comb begin
    any_en    = 1'b0;
    first_idx = '0;
    has_next  = 1'b0;
    next_idx  = '0;
    for (int i = NFIELDS - 1; i >= 0; i--) begin
      if (len_tab[i] != '0) begin
        any_en    = 1'b1;
        first_idx = IDX_W'(i);
        if (i > int'(cur)) begin
          has_next = 1'b1;
          next_idx = IDX_W'(i);
        end
      end
    end
  end

  // Zero-padding above the word makes bit positions >= DATA_W read as 0.
  always_comb begin
    wide    = {{FIELD_W{1'b0}}, hold} >> lsb_tab[cur];
    len_eff = (len_tab[cur] > LEN_W'(FIELD_W)) ? LEN_W'(FIELD_W) : len_tab[cur];
    mask    = '0;
    for (int i = 0; i < FIELD_W; i++) begin
      mask[i] = (LEN_W'(i) < len_eff);
    end
  end

  assign cfg_busy  = (state == EMIT);
  assign out_valid = (state == EMIT);
  assign out_last  = (state == EMIT) && !has_next;
  assign out_idx   = (state == EMIT) ? cur : '0;
  assign out_data  = (state == EMIT) ? (wide[FIELD_W-1:0] & mask) : '0;
  assign in_ready  = (state == IDLE) || ((state == EMIT) && out_ready && out_last);
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;

`ifdef BITFIELD_EXTRACT_SCHED_RANGE_CHK_EN
  assign cfg_ok = ((int'(cfg_lsb) + int'(cfg_len)) <= DATA_W) && (int'(cfg_len) <= FIELD_W);
`else
  assign cfg_ok = 1'b1;
`endif

  always_comb begin
    state_n = state;
    cur_n   = cur;
    case (state)
      IDLE: begin
        if (accept && any_en) begin
          state_n = EMIT;
          cur_n   = first_idx;
        end
      end
      EMIT: begin
        if (handoff) begin
          if (!out_last) begin
            cur_n = next_idx;
          end else if (accept && any_en) begin
            cur_n = first_idx;
          end else begin
            state_n = IDLE;
            cur_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cur       <= '0;
      hold      <= '0;
      field_cnt <= '0;
      for (int i = 0; i < NFIELDS; i++) begin
        lsb_tab[i] <= '0;
        len_tab[i] <= '0;
      end
    end else begin
      state <= state_n;
      cur   <= cur_n;
      if (accept) hold <= in_data;
      if (handoff) field_cnt <= field_cnt + 16'd1;
      if (cfg_we && (state == IDLE) && cfg_ok) begin
        lsb_tab[cfg_idx] <= cfg_lsb;
        len_tab[cfg_idx] <= cfg_len;
      end
    end
  end

`ifdef BITFIELD_EXTRACT_SCHED_RANGE_CHK_EN
  always_ff @(posedge clock) begin
    if (!reset) cfg_err <= 1'b0;
    else if (cfg_we && (state == IDLE) && !cfg_ok) cfg_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bitfield_extract_sched.sv
// Directed bench for bitfield_extract_sched: table-driven single-field vectors plus
// hand-written sequences for skip/backpressure, back-to-back words, cfg lockout and reset.
module tb_bitfield_extract_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [3:0]  cfg_lsb = '0;
  logic [3:0]  cfg_len = '0;
  logic        cfg_busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic [15:0] field_cnt;
`ifdef BITFIELD_EXTRACT_SCHED_RANGE_CHK_EN
  logic        cfg_err;
`endif

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [3:0]  lsb;
    logic [3:0]  len;
    logic [15:0] data;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[$];

  bitfield_extract_sched dut (
    .clock(clock), .reset(reset),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lsb(cfg_lsb), .cfg_len(cfg_len),
    .cfg_busy(cfg_busy),
`ifdef BITFIELD_EXTRACT_SCHED_RANGE_CHK_EN
    .cfg_err(cfg_err),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .field_cnt(field_cnt)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic cfg_write(input logic [1:0] idx, input logic [3:0] lsb, input logic [3:0] len);
    cfg_we  = 1'b1;
    cfg_idx = idx;
    cfg_lsb = lsb;
    cfg_len = len;
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] data);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  // Scoreboard check of one presented field, followed by its handoff
  task automatic take_field(input string name, input logic [1:0] idx, input logic last);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: expected queue empty", name);
      return;
    end
    e = exp_q.pop_front();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"},  32'(out_data), 32'(e));
    chk({name, "_idx"},   32'(out_idx), 32'(idx));
    chk({name, "_last"},  32'(out_last), 32'(last));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt++;
  endtask

  initial begin
    vecs.push_back('{lsb: 4'd0,  len: 4'd8, data: 16'hABCD, exp: 8'hCD});
    vecs.push_back('{lsb: 4'd4,  len: 4'd8, data: 16'hABCD, exp: 8'hBC});
    vecs.push_back('{lsb: 4'd8,  len: 4'd4, data: 16'hABCD, exp: 8'h0B});
    vecs.push_back('{lsb: 4'd15, len: 4'd1, data: 16'h8000, exp: 8'h01});
    vecs.push_back('{lsb: 4'd3,  len: 4'd5, data: 16'h00F8, exp: 8'h1F});
    vecs.push_back('{lsb: 4'd8,  len: 4'd8, data: 16'h5A00, exp: 8'h5A});
`ifndef BITFIELD_EXTRACT_SCHED_RANGE_CHK_EN
    vecs.push_back('{lsb: 4'd12, len: 4'd8,  data: 16'hF000, exp: 8'h0F});
    vecs.push_back('{lsb: 4'd0,  len: 4'd15, data: 16'hFFFF, exp: 8'hFF});
    vecs.push_back('{lsb: 4'd10, len: 4'd12, data: 16'hFC00, exp: 8'h3F});
`endif

    // 1. reset state and all-disabled consume
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_field_cnt", 32'(field_cnt), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    chk("rst_cfg_busy",  32'(cfg_busy), 32'd0);
    chk("rst_out_data",  32'(out_data), 32'd0);
`ifdef BITFIELD_EXTRACT_SCHED_RANGE_CHK_EN
    chk("rst_cfg_err",   32'(cfg_err), 32'd0);
`endif
    send_word(16'h1234);
    chk("empty_out_valid", 32'(out_valid), 32'd0);
    chk("empty_in_ready",  32'(in_ready), 32'd1);

    // 2. single field
    cfg_write(2'd0, 4'd1, 4'd4);
    send_word(16'h001F);
    exp_q.push_back(8'h0F);
    take_field("single", 2'd0, 1'b1);
    chk("single_cnt",  32'(field_cnt), 32'(exp_cnt));
    chk("single_idle", 32'(out_valid), 32'd0);

    // Table-driven single-field extraction vectors on entry 0
    foreach (vecs[i]) begin
      cfg_write(2'd0, vecs[i].lsb, vecs[i].len);
      send_word(vecs[i].data);
      exp_q.push_back(vecs[i].exp);
      take_field($sformatf("vec%0d", i), 2'd0, 1'b1);
      chk($sformatf("vec%0d_cnt", i), 32'(field_cnt), 32'(exp_cnt));
    end

    // 3. skip disabled entry, backpressure holds field stable
    cfg_write(2'd0, 4'd1, 4'd3);
    cfg_write(2'd1, 4'd0, 4'd0);
    cfg_write(2'd2, 4'd8, 4'd8);
    cfg_write(2'd3, 4'd0, 4'd0);
    send_word(16'hA50E);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d_data", c), 32'(out_data), 32'h07);
      chk($sformatf("stall%0d_idx", c),  32'(out_idx), 32'd0);
      chk($sformatf("stall%0d_last", c), 32'(out_last), 32'd0);
      chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
      tick();
    end
    exp_q.push_back(8'h07);
    take_field("skip0", 2'd0, 1'b0);
    exp_q.push_back(8'hA5);
    take_field("skip2", 2'd2, 1'b1);
    chk("skip_idle", 32'(out_valid), 32'd0);
    chk("skip_cnt",  32'(field_cnt), 32'(exp_cnt));

    // 4. back-to-back words with in_valid held high
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0102;
    tick();
    for (int c = 0; c < 4; c++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      chk($sformatf("b2b%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("b2b%0d_data", c),  32'(out_data), 32'(e));
      chk($sformatf("b2b%0d_idx", c),   32'(out_idx), (c % 2 == 0) ? 32'd0 : 32'd2);
      if (c == 0) begin
        chk("b2b_in_ready_mid", 32'(in_ready), 32'd0);
        in_data = 16'hFF00;
      end
      if (c == 1) chk("b2b_in_ready_last", 32'(in_ready), 32'd1);
      if (c == 2) in_valid = 1'b0;
      tick();
      exp_cnt++;
    end
    out_ready = 1'b0;
    chk("b2b_idle", 32'(out_valid), 32'd0);
    chk("b2b_cnt",  32'(field_cnt), 32'(exp_cnt));

    // 5. cfg write during EMIT is ignored
    send_word(16'hA50E);
    chk("emit_busy", 32'(cfg_busy), 32'd1);
    cfg_write(2'd1, 4'd0, 4'd8);
    exp_q.push_back(8'h07);
    take_field("lock0", 2'd0, 1'b0);
    exp_q.push_back(8'hA5);
    take_field("lock2", 2'd2, 1'b1);
`ifdef BITFIELD_EXTRACT_SCHED_RANGE_CHK_EN
    cfg_write(2'd3, 4'd12, 4'd8);
    chk("range_cfg_err", 32'(cfg_err), 32'd1);
`endif
    send_word(16'h00FF);
    exp_q.push_back(8'h07);
    take_field("after0", 2'd0, 1'b0);
    exp_q.push_back(8'h00);
    take_field("after2", 2'd2, 1'b1);
    chk("after_idle", 32'(out_valid), 32'd0);

    // 6. reset during EMIT
    send_word(16'h1234);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt",   32'(field_cnt), 32'd0);
    chk("mid_rst_busy",  32'(cfg_busy), 32'd0);
`ifdef BITFIELD_EXTRACT_SCHED_RANGE_CHK_EN
    chk("mid_rst_cfg_err", 32'(cfg_err), 32'd0);
`endif
    send_word(16'hFFFF);
    chk("mid_rst_table_cleared", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitfield_extract_sched.md
Name: bitfield_extract_sched

Overview:
- Sequencer for the bit-slice extraction datapath. It accepts one input word per transaction and holds it.
- It emits a programmed list of fields (lsb, len) one per cycle, using valid/ready handshakes on both sides.
- It replaces hard-wired head/slice assigns with a runtime-configurable field table.
- It sits between a packet or word source and downstream per-field consumers.

Parameters:
- DATA_W, 16, input word width.
- NFIELDS, 4, number of field-table entries.
- FIELD_W, 8, output field width. Extracted fields are zero-extended or truncated to this width.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clock rising edge).
- cfg_we  in  1  field-table write strobe.
- cfg_idx  in  clog2(NFIELDS)  table entry to write.
- cfg_lsb  in  clog2(DATA_W)  field start bit.
- cfg_len  in  clog2(FIELD_W)+1  field length; 0 = entry disabled.
- cfg_busy  out  1  high when state != IDLE; cfg writes are ignored while high.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  DATA_W  input word.
- out_valid  out  1  field valid.
- out_ready  in  1  downstream accepts field.
- out_data  out  FIELD_W  extracted field, zero-extended.
- out_idx  out  clog2(NFIELDS)  table index of the current field.
- out_last  out  1  current field is the last enabled entry.
- field_cnt  out  16  count of fields handed off; wraps modulo 2^16.

Behaviour:
- State machine: IDLE, EMIT.
- Reset (reset==0 at an edge):
  - state=IDLE.
  - All table entries: lsb=0, len=0.
  - Hold register = 0; field_cnt = 0.
  - Outputs: out_valid=0, out_data=0, out_idx=0, out_last=0, cfg_busy=0.
  - Reset mid-EMIT discards the held word and any unsent fields.
- Config writes:
  - cfg_we in IDLE writes table[cfg_idx] at the edge.
  - cfg_we in EMIT is ignored; no side effect.
- in_ready = (state==IDLE) || (state==EMIT && out_ready && out_last).
- Accept rule (in_valid && in_ready):
  - Latch in_data into the hold register.
  - Find the lowest enabled entry (len != 0), using the table as it stands before any same-cycle cfg write.
  - If one exists: state=EMIT, cur=that index.
  - If none exists: the word is consumed, no field is emitted, state stays IDLE.
- EMIT outputs:
  - out_valid=1 and out_idx=cur.
  - out_data = (hold >> lsb[cur]) masked to min(len[cur], FIELD_W) bits, zero-extended.
  - Bit positions at or above DATA_W read as 0.
  - out_last = 1 if no enabled entry exists with index > cur.
- Held field: while out_valid && !out_ready, out_data, out_idx and out_last are stable.
- Field handoff (out_valid && out_ready):
  - field_cnt increments.
  - If !out_last: cur = next enabled index above cur.
  - If out_last and in_valid: accept the new word in the same cycle (back-to-back, no bubble) and restart from the lowest enabled entry.
  - If out_last and !in_valid: state=IDLE.
- Latency and throughput:
  - First field is valid on the cycle after input acceptance.
  - One field per cycle with out_ready held high.
  - A word with k enabled fields sustains k cycles per word.
- Outside EMIT: out_valid=0 and out_data=0.
- field_cnt wraps from 0xFFFF to 0x0000.

Optional Feature:
- Macro: BITFIELD_EXTRACT_SCHED_RANGE_CHK_EN.
- With the macro defined:
  - Adds output cfg_err (1 bit, reset 0).
  - A cfg write with lsb+len > DATA_W or len > FIELD_W is rejected: the entry is unchanged and cfg_err is set sticky until reset.
- Without the macro:
  - No cfg_err port; all writes are accepted.
  - Length is clamped to FIELD_W and bits at or above DATA_W read as 0.

Test Plan:
1. Reset then readout: reset=0 for 2 cycles, then 1 → out_valid=0, field_cnt=0, in_ready=1. Feed in_data=0x1234 with an all-disabled table → word consumed, out_valid stays 0.
2. Single field: cfg[0]={lsb=1,len=4}, in_data=0x001F → next cycle out_data=0x0F, out_idx=0, out_last=1; field_cnt=1 after handoff.
3. Skip and backpressure:
   - Config: cfg[0]={1,3}, cfg[2]={8,8}, cfg[1] disabled.
   - Stimulus: in_data=0xA50E, out_ready low for 3 cycles, then high.
   - Response: out_data=0x07 (idx 0) held stable while stalled, then out_data=0xA5 (idx 2, last).
4. Back-to-back:
   - Config as in scenario 3.
   - Stimulus: two words 0x0102 and 0xFF00 with out_ready=1 and in_valid held high.
   - Response: out_valid continuously high for 4 cycles (0x01, 0x01, 0x00, 0xFF), and the second word is accepted on the first word's last handoff.
5. Boundaries:
   - cfg[0]={lsb=12,len=8} with in_data=0xF000 → out_data=0x0F, since bits ≥16 read as zero.
   - cfg write during EMIT → table unchanged after return to IDLE.
   - With the macro defined: the same {12,8} write → cfg_err=1 and the entry is unchanged.
6. Reset mid-operation: reset=0 during EMIT at idx 0 → next cycle out_valid=0, all entries disabled, field_cnt=0.
